// File: rtl/viterbi_trellis_sched_if.sv
// Handshake and bank-control bundle between the ACS selection stage, the
// trellis scheduler and the trellis memory/TBU instances.
interface viterbi_trellis_sched_if #(parameter int ADDR_W = 10);
    logic                  enable;
    logic                  sel_valid;
    logic                  flush;
    logic [3:0]            bank_wr_en;
    logic [4*ADDR_W-1:0]   bank_addr;
    logic [1:0]            tbu_en;
    logic                  tbu_sel;
    logic [1:0]            wr_bank;
    logic                  busy;
    logic                  done;

    modport master (
        output enable, sel_valid, flush,
        input  bank_wr_en, bank_addr, tbu_en, tbu_sel, wr_bank, busy, done
    );

    modport slave (
        input  enable, sel_valid, flush,
        output bank_wr_en, bank_addr, tbu_en, tbu_sel, wr_bank, busy, done
    );
endinterface

// File: rtl/viterbi_trellis_sched.sv
// Trellis bank scheduler: rotates four banks between write, read and idle
// roles, drives per-bank strobes/addresses, TBU enables and end-of-stream drain.
module viterbi_trellis_sched #(
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    viterbi_trellis_sched_if.slave   bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_LAST   = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   DRAIN_LAST = {(ADDR_W+1){1'b1}};

    state_t                state_r, state_s;
    logic [ADDR_W-1:0]     wr_cnt_r;
    logic [ADDR_W-1:0]     rd_cnt_s;
    logic [1:0]            wr_bank_r;
    logic [1:0]            blk_cnt_r, blk_nxt_s;
    logic [ADDR_W:0]       drain_cnt_r;
    logic                  slot_s, write_s, wrap_s;
    logic [3:0]            wr_mask_s;
    wire  [4*ADDR_W-1:0]   addr_map_s;

    logic [3:0]            bank_wr_en_r;
    logic [4*ADDR_W-1:0]   bank_addr_r;
    logic [1:0]            tbu_en_r;
    logic                  tbu_sel_r;
    logic [1:0]            wr_bank_out_r;
    logic                  busy_r, done_r;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state plus slot acceptance; enable low forces IDLE from anywhere.
    always_comb begin
        state_s = state_r;
        slot_s  = 1'b0;
        write_s = 1'b0;
        if (!bus.enable) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.sel_valid) begin
                        state_s = ST_FILL;
                        slot_s  = 1'b1;
                        write_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_FILL, ST_RUN: begin
                    slot_s  = bus.sel_valid;
                    write_s = bus.sel_valid;
                    if (bus.flush) begin
                        state_s = ST_FLUSH;
                    end else if ((state_r == ST_FILL) && blk_nxt_s[1]) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_FLUSH: begin
                    slot_s = 1'b1;
                    if (drain_cnt_r == DRAIN_LAST) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_FLUSH;
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    assign wrap_s    = slot_s && (wr_cnt_r == CNT_LAST);
    assign blk_nxt_s = (wrap_s && (blk_cnt_r != 2'd3)) ? (blk_cnt_r + 2'd1) : blk_cnt_r;
    assign rd_cnt_s  = ~wr_cnt_r;
    assign wr_mask_s = 4'b0001 << wr_bank_r;

    // Bank role by distance from the write bank: 0 write, 2 idle, 1/3 read.
    for (genvar g = 0; g < 4; g++) begin : g_map
        logic [1:0] dist_s;
        assign dist_s = 2'(g) - wr_bank_r;
        assign addr_map_s[g*ADDR_W +: ADDR_W] =
            (dist_s == 2'd0) ? wr_cnt_r :
            (dist_s == 2'd2) ? {ADDR_W{1'b0}} : rd_cnt_s;
    end

    // Slot counters, bank rotation and drain counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt_r    <= {ADDR_W{1'b0}};
            wr_bank_r   <= 2'd0;
            blk_cnt_r   <= 2'd0;
            drain_cnt_r <= {(ADDR_W+1){1'b0}};
        end else if (state_s == ST_IDLE) begin
            wr_cnt_r    <= {ADDR_W{1'b0}};
            wr_bank_r   <= 2'd0;
            blk_cnt_r   <= 2'd0;
            drain_cnt_r <= {(ADDR_W+1){1'b0}};
        end else begin
            if (slot_s) begin
                wr_cnt_r <= wr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            if (wrap_s) begin
                wr_bank_r <= wr_bank_r + 2'd1;
            end
            blk_cnt_r <= blk_nxt_s;
            if (state_r == ST_FLUSH) begin
                drain_cnt_r <= drain_cnt_r + {{ADDR_W{1'b0}}, 1'b1};
            end else begin
                drain_cnt_r <= {(ADDR_W+1){1'b0}};
            end
        end
    end

    // Output registers; bank mapping is captured only on accepted slots so stalls hold it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_wr_en_r  <= 4'b0000;
            bank_addr_r   <= {(4*ADDR_W){1'b0}};
            tbu_en_r      <= 2'b00;
            tbu_sel_r     <= 1'b0;
            wr_bank_out_r <= 2'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else if (state_s == ST_IDLE) begin
            bank_wr_en_r  <= 4'b0000;
            bank_addr_r   <= {(4*ADDR_W){1'b0}};
            tbu_en_r      <= 2'b00;
            tbu_sel_r     <= 1'b0;
            wr_bank_out_r <= 2'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            bank_wr_en_r <= write_s ? wr_mask_s : 4'b0000;
            if (slot_s) begin
                bank_addr_r   <= addr_map_s;
                wr_bank_out_r <= wr_bank_r;
                tbu_sel_r     <= wr_bank_r[0];
            end
            busy_r <= (state_s != ST_DONE);
            done_r <= (state_s == ST_DONE);
            if (state_s == ST_FLUSH) begin
                tbu_en_r <= 2'b11;
            end else if (state_s == ST_DONE) begin
                tbu_en_r <= 2'b00;
            end else begin
                tbu_en_r <= tbu_en_r | {(blk_nxt_s == 2'd3), blk_nxt_s[1]};
            end
        end
    end

    assign bus.bank_wr_en = bank_wr_en_r;
    assign bus.bank_addr  = bank_addr_r;
    assign bus.tbu_en     = tbu_en_r;
    assign bus.tbu_sel    = tbu_sel_r;
    assign bus.wr_bank    = wr_bank_out_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
endmodule

// File: tb/tb_viterbi_trellis_sched.sv
// Bench for viterbi_trellis_sched (ADDR_W=3): slot-count model compared every
// cycle, plus hand-computed literal pins at key points.
module tb_viterbi_trellis_sched;
    localparam int AW = 3;
    localparam int D  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    viterbi_trellis_sched_if #(.ADDR_W(AW)) bus();
    viterbi_trellis_sched #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    // Model: phase 0 idle, 1 fill/run, 2 flush, 3 done; m_n = slots consumed.
    int m_phase = 0;
    int m_n     = 0;
    int m_drain = 0;

    logic [3:0]    x_en, e_en;
    logic [4*AW-1:0] x_addr, e_addr;
    logic [1:0]    x_tbu, e_tbu, x_wb, e_wb;
    logic          x_sel, e_sel, x_busy, e_busy, x_done, e_done;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [4*AW-1:0] addr_for(input int n);
        logic [4*AW-1:0] r;
        int b;
        int a;
        r = '0;
        b = (n / D) % 4;
        a = n % D;
        for (int i = 0; i < 4; i++) begin
            int d;
            int v;
            d = (i - b + 4) % 4;
            v = (d == 0) ? a : ((d == 2) ? 0 : (D - 1 - a));
            r[i*AW +: AW] = v[AW-1:0];
        end
        return r;
    endfunction

    task automatic zero_x();
        x_en = 4'b0000; x_addr = '0; x_tbu = 2'b00; x_wb = 2'd0;
        x_sel = 1'b0; x_busy = 1'b0; x_done = 1'b0;
    endtask

    task automatic put_slot(input int n, input bit wr);
        int b;
        b = (n / D) % 4;
        x_en   = wr ? (4'b0001 << b) : 4'b0000;
        x_addr = addr_for(n);
        x_wb   = b[1:0];
        x_sel  = x_wb[0];
    endtask

    // Predict outputs after the next edge from the inputs being applied.
    task automatic model(input bit en, input bit sv, input bit fl);
        if (!en) begin
            zero_x(); m_phase = 0; m_n = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (sv) begin
                        put_slot(0, 1'b1); m_n = 1; m_phase = 1;
                        x_busy = 1'b1; x_done = 1'b0; x_tbu = 2'b00;
                    end else begin
                        zero_x();
                    end
                end
                1: begin
                    if (sv) begin
                        put_slot(m_n, 1'b1); m_n++;
                    end else begin
                        x_en = 4'b0000;
                    end
                    x_busy = 1'b1; x_done = 1'b0;
                    x_tbu = {m_n >= 3*D, m_n >= 2*D};
                    if (fl) begin
                        m_phase = 2; m_drain = 0; x_tbu = 2'b11;
                    end
                end
                2: begin
                    put_slot(m_n, 1'b0); m_n++; m_drain++;
                    if (m_drain == 2*D) begin
                        m_phase = 3; x_busy = 1'b0; x_done = 1'b1; x_tbu = 2'b00;
                    end else begin
                        x_busy = 1'b1; x_done = 1'b0; x_tbu = 2'b11;
                    end
                end
                default: begin
                    zero_x(); m_phase = 0; m_n = 0;
                end
            endcase
        end
    endtask

    task automatic commit();
        e_en = x_en; e_addr = x_addr; e_tbu = x_tbu; e_wb = x_wb;
        e_sel = x_sel; e_busy = x_busy; e_done = x_done;
    endtask

    task automatic cyc(input bit en, input bit sv, input bit fl);
        bus.enable = en; bus.sel_valid = sv; bus.flush = fl;
        model(en, sv, fl);
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.enable = 1'b0; bus.sel_valid = 1'b0; bus.flush = 1'b0;
        zero_x(); commit(); m_phase = 0; m_n = 0;
        #1;
        cmp("rst_busy", 32'(bus.busy), 32'd0);
        cmp("rst_addr", 32'(bus.bank_addr), 32'd0);
        cmp("rst_tbu", 32'(bus.tbu_en), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            cmp("bank_wr_en", 32'(bus.bank_wr_en), 32'(e_en));
            cmp("bank_addr", 32'(bus.bank_addr), 32'(e_addr));
            cmp("tbu_en", 32'(bus.tbu_en), 32'(e_tbu));
            cmp("tbu_sel", 32'(bus.tbu_sel), 32'(e_sel));
            cmp("wr_bank", 32'(bus.wr_bank), 32'(e_wb));
            cmp("busy", 32'(bus.busy), 32'(e_busy));
            cmp("done", 32'(bus.done), 32'(e_done));
        end
    end

    initial begin
        bus.enable = 1'b0; bus.sel_valid = 1'b0; bus.flush = 1'b0;
        zero_x(); commit();
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cmp("pin_init_busy", 32'(bus.busy), 32'd0);

        // Continuous fill through one full rotation back to bank 0.
        for (int i = 0; i <= 32; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            if (i == 0) begin
                cmp("pin_s0_addr", 32'(bus.bank_addr), 32'h0E38);
                cmp("pin_s0_wen", 32'(bus.bank_wr_en), 32'h1);
            end
            if (i == 8) begin
                cmp("pin_s8_addr", 32'(bus.bank_addr), 32'h01C7);
                cmp("pin_s8_wen", 32'(bus.bank_wr_en), 32'h2);
                cmp("pin_s8_wb", 32'(bus.wr_bank), 32'd1);
            end
            if (i == 14) cmp("pin_s14_tbu", 32'(bus.tbu_en), 32'h0);
            if (i == 15) cmp("pin_s15_tbu", 32'(bus.tbu_en), 32'h1);
            if (i == 24) begin
                cmp("pin_s24_tbu", 32'(bus.tbu_en), 32'h3);
                cmp("pin_s24_wb", 32'(bus.wr_bank), 32'd3);
            end
            if (i == 32) cmp("pin_s32_wb", 32'(bus.wr_bank), 32'd0);
        end

        // Stalls interleaved in RUN: 8 valid slots out of 16 cycles.
        for (int j = 0; j < 16; j++) begin
            cyc(1'b1, (j % 2) == 0, 1'b0);
        end
        cmp("pin_stall_wen", 32'(bus.bank_wr_en), 32'h0);
        cmp("pin_stall_wb", 32'(bus.wr_bank), 32'd1);

        // Asynchronous reset in the middle of RUN.
        do_reset();
        cyc(1'b1, 1'b0, 1'b1);
        cmp("pin_idle_flush", 32'(bus.busy), 32'd0);

        // 20 slots, flush together with slot 20, second flush ignored while draining.
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        cmp("pin_f_wen", 32'(bus.bank_wr_en), 32'h4);
        cmp("pin_f_tbu", 32'(bus.tbu_en), 32'h3);
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 1'b0, k == 5);
            if (k == 14) cmp("pin_f14_done", 32'(bus.done), 32'd0);
            if (k == 15) begin
                cmp("pin_f15_done", 32'(bus.done), 32'd1);
                cmp("pin_f15_tbu", 32'(bus.tbu_en), 32'h0);
            end
        end
        cyc(1'b1, 1'b0, 1'b0);
        cmp("pin_post_done", 32'(bus.done), 32'd0);

        // Abort at slot 5 of FILL, then restart from bank 0 address 0.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cmp("pin_abort_wen", 32'(bus.bank_wr_en), 32'h0);
        cmp("pin_abort_done", 32'(bus.done), 32'd0);
        cyc(1'b1, 1'b1, 1'b0);
        cmp("pin_restart_addr", 32'(bus.bank_addr), 32'h0E38);
        cmp("pin_restart_wen", 32'(bus.bank_wr_en), 32'h1);
        repeat (2) cyc(1'b1, 1'b0, 1'b0);

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
